// File: rtl/tc_sram_arbiter_pkg.sv
// tc_sram_arb_pkg: shared types and helpers for the tc_sram arbiter.
//   state_e   : init FSM states (used only when TC_SRAM_ARB_INIT_EN is defined)
//   tag_t     : in-flight read tag {valid, requester index, out-of-range flag}
//   idx_width : width of a requester index for a given requester count
package tc_sram_arb_pkg;

    // Widest requester index a tag can carry (up to 256 requesters).
    localparam int unsigned MAX_IDX_W = 8;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic                 valid;
        logic [MAX_IDX_W-1:0] idx;
        logic                 oob;
    } tag_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tc_sram_arbiter_if.sv
// tc_sram_arbiter_if: requester-side bus of the tc_sram arbiter.
//   req_i/we_i/addr_i/wdata_i/be_i : per-requester access, held until granted
//   gnt_o                          : one-hot grant, same cycle as the request
//   rvalid_o/rdata_o               : one-hot read response + shared read data
//   init_done_o                    : memory ready, grants possible
// master modport = requester side, slave modport = arbiter side.
interface tc_sram_arbiter_if #(
    parameter int unsigned NumReq    = 4,
    parameter int unsigned AddrWidth = 10,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned BeWidth   = 4
);
    logic [NumReq-1:0]                req_i;
    logic [NumReq-1:0]                we_i;
    logic [NumReq-1:0][AddrWidth-1:0] addr_i;
    logic [NumReq-1:0][DataWidth-1:0] wdata_i;
    logic [NumReq-1:0][BeWidth-1:0]   be_i;
    logic [NumReq-1:0]                gnt_o;
    logic [NumReq-1:0]                rvalid_o;
    logic [DataWidth-1:0]             rdata_o;
    logic                             init_done_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i,
        input  gnt_o, rvalid_o, rdata_o, init_done_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i,
        output gnt_o, rvalid_o, rdata_o, init_done_o
    );
endinterface

// File: rtl/tc_sram_arbiter_rr.sv
// tc_sram_arb_rr: round-robin pointer and priority pick.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   en_i          : grants allowed (memory ready)
//   req_i         : request vector
//   gnt_o         : one-hot grant (combinational)
//   idx_o         : index of the winner
//   valid_o       : a grant was issued this cycle
// The first active request at or above the pointer wins, wrapping; the
// pointer moves to winner+1 on every grant and holds otherwise.
module tc_sram_arb_rr
    import tc_sram_arb_pkg::*;
#(
    parameter  int unsigned NumReq = 4,
    localparam int unsigned IdxW   = idx_width(NumReq)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic [NumReq-1:0] req_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   idx_o,
    output logic              valid_o
);

    logic [IdxW-1:0] r_ptr;

    always_comb begin
        int unsigned j;
        j       = 0;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            j = (32'(r_ptr) + k) % NumReq;
            if (en_i && !valid_o && req_i[j]) begin
                valid_o  = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IdxW'(j);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_ptr <= '0;
        end else if (valid_o) begin
            r_ptr <= (idx_o == IdxW'(NumReq - 1)) ? '0 : idx_o + IdxW'(1);
        end
    end

endmodule

// File: rtl/tc_sram_arbiter.sv
// tc_sram_arbiter: shares one single-port tc_sram between NumReq requesters.
//   clk_i, rst_ni  : clock, synchronous active-low reset
//   bus (slave)    : requester bus (req/we/addr/wdata/be in, gnt/rvalid/rdata/init_done out)
//   sram_*_o       : access to the tc_sram macro (one per cycle)
//   sram_rdata_i   : read data from the macro, Latency cycles after the read
// Read tags ride a Latency-deep shift register so the response is routed to
// the issuing requester without ever stalling.
// Optional: TC_SRAM_ARB_INIT_EN adds an INIT->RUN FSM that zeroes the whole
// memory after reset before any grant is given.
module tc_sram_arbiter
    import tc_sram_arb_pkg::*;
#(
    parameter  int unsigned NumReq    = 4,
    parameter  int unsigned NumWords  = 1024,
    parameter  int unsigned DataWidth = 32,
    parameter  int unsigned ByteWidth = 8,
    parameter  int unsigned Latency   = 1,
    localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth,
    localparam int unsigned IdxW      = idx_width(NumReq)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    tc_sram_arbiter_if.slave     bus,
    output logic                 sram_req_o,
    output logic                 sram_we_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0] sram_wdata_o,
    output logic [BeWidth-1:0]   sram_be_o,
    input  logic [DataWidth-1:0] sram_rdata_i
);

    // Depth widened by one bit so addr >= NumWords is a plain compare.
    localparam logic [AddrWidth:0] NW_EXT = (AddrWidth + 1)'(NumWords);

    logic                 r_init_done;
    logic [NumReq-1:0]    w_gnt;
    logic [IdxW-1:0]      w_idx;
    logic                 w_gvld;
    logic [AddrWidth-1:0] w_sel_addr;
    logic                 w_oob;
    logic                 w_init_wr;
    tag_t                 w_push;
    tag_t                 w_tail;
    tag_t                 r_tag [Latency];

    tc_sram_arb_rr #(.NumReq(NumReq)) u_rr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (r_init_done),
        .req_i   (bus.req_i),
        .gnt_o   (w_gnt),
        .idx_o   (w_idx),
        .valid_o (w_gvld)
    );

    assign bus.gnt_o       = w_gnt;
    assign bus.init_done_o = r_init_done;
    assign w_sel_addr      = bus.addr_i[w_idx];
    assign w_oob           = ({1'b0, w_sel_addr} >= NW_EXT);

`ifdef TC_SRAM_ARB_INIT_EN
    state_e               r_state;
    logic [AddrWidth-1:0] r_init_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= INIT;
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    r_init_cnt <= r_init_cnt + AddrWidth'(1);
                    if (r_init_cnt == AddrWidth'(NumWords - 1)) begin
                        r_state     <= RUN;
                        r_init_done <= 1'b1;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    // Qualified by rst_ni so the macro sees no writes while reset is held.
    assign w_init_wr = (r_state == INIT) && rst_ni;
`else
    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_init_done <= 1'b0;
        else         r_init_done <= 1'b1;
    end

    assign w_init_wr = 1'b0;
`endif

    // Out-of-range accesses are granted but never reach the macro.
    always_comb begin
        sram_req_o   = w_gvld && !w_oob;
        sram_we_o    = w_gvld && bus.we_i[w_idx];
        sram_addr_o  = w_sel_addr;
        sram_wdata_o = bus.wdata_i[w_idx];
        sram_be_o    = bus.be_i[w_idx];
        if (w_init_wr) begin
            sram_req_o   = 1'b1;
            sram_we_o    = 1'b1;
            sram_wdata_o = '0;
            sram_be_o    = '1;
        end
        `ifdef TC_SRAM_ARB_INIT_EN
        if (w_init_wr) sram_addr_o = r_init_cnt;
        `endif
    end

    always_comb begin
        w_push                = '0;
        w_push.valid          = w_gvld && !bus.we_i[w_idx];
        w_push.idx[IdxW-1:0]  = w_idx;
        w_push.oob            = w_oob;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < Latency; i++) r_tag[i] <= '0;
        end else begin
            r_tag[0] <= w_push;
            for (int i = 1; i < Latency; i++) r_tag[i] <= r_tag[i-1];
        end
    end

    // The tag leaving the pipe lines up with the macro's read data.
    assign w_tail = r_tag[Latency-1];

    always_comb begin
        for (int unsigned i = 0; i < NumReq; i++) begin
            bus.rvalid_o[i] = w_tail.valid && (w_tail.idx == MAX_IDX_W'(i));
        end
        bus.rdata_o = (w_tail.valid && !w_tail.oob) ? sram_rdata_i : '0;
    end

endmodule

// File: tb/tb_tc_sram_arbiter.sv
// Directed bench for tc_sram_arbiter: three instances cover Latency=1 with a
// real memory model, Latency=2 with a 1000-word (non power of 2) depth, and
// Latency=3. Read data for the latter two is a fixed function of address.
module tb_tc_sram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rst1_n;
    int   n_cmp = 0;
    int   n_err = 0;

    tc_sram_arbiter_if #(.NumReq(4), .AddrWidth(10), .DataWidth(32), .BeWidth(4)) bus0 ();
    tc_sram_arbiter_if #(.NumReq(4), .AddrWidth(10), .DataWidth(32), .BeWidth(4)) bus1 ();
    tc_sram_arbiter_if #(.NumReq(4), .AddrWidth(10), .DataWidth(32), .BeWidth(4)) bus2 ();

    logic        s0_req, s0_we, s1_req, s1_we, s2_req, s2_we;
    logic [9:0]  s0_addr, s1_addr, s2_addr;
    logic [31:0] s0_wdata, s1_wdata, s2_wdata;
    logic [3:0]  s0_be, s1_be, s2_be;
    logic [31:0] s0_rdata, s1_rdata, s2_rdata;

    tc_sram_arbiter #(.NumReq(4), .NumWords(1024), .DataWidth(32), .ByteWidth(8), .Latency(1)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus0),
        .sram_req_o(s0_req), .sram_we_o(s0_we), .sram_addr_o(s0_addr),
        .sram_wdata_o(s0_wdata), .sram_be_o(s0_be), .sram_rdata_i(s0_rdata));

    tc_sram_arbiter #(.NumReq(4), .NumWords(1000), .DataWidth(32), .ByteWidth(8), .Latency(2)) u1 (
        .clk_i(clk), .rst_ni(rst1_n), .bus(bus1),
        .sram_req_o(s1_req), .sram_we_o(s1_we), .sram_addr_o(s1_addr),
        .sram_wdata_o(s1_wdata), .sram_be_o(s1_be), .sram_rdata_i(s1_rdata));

    tc_sram_arbiter #(.NumReq(4), .NumWords(1024), .DataWidth(32), .ByteWidth(8), .Latency(3)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus2),
        .sram_req_o(s2_req), .sram_we_o(s2_we), .sram_addr_o(s2_addr),
        .sram_wdata_o(s2_wdata), .sram_be_o(s2_be), .sram_rdata_i(s2_rdata));

    // Latency-1 byte-enabled SRAM model.
    logic [31:0] mem0 [1024] = '{default: 32'h0};
    always @(posedge clk) begin
        if (s0_req) begin
            if (s0_we) begin
                for (int b = 0; b < 4; b++)
                    if (s0_be[b]) mem0[s0_addr][b*8 +: 8] <= s0_wdata[b*8 +: 8];
            end else begin
                s0_rdata <= mem0[s0_addr];
            end
        end
    end

    // Fixed-content models: word at address a reads as 0xC0DE0000 | a.
    logic [31:0] p1 [2];
    logic [31:0] p2 [3];
    always @(posedge clk) begin
        p1[0] <= 32'hC0DE0000 | {22'd0, s1_addr};
        p1[1] <= p1[0];
        p2[0] <= 32'hC0DE0000 | {22'd0, s2_addr};
        p2[1] <= p2[0];
        p2[2] <= p2[1];
    end
    assign s1_rdata = p1[1];
    assign s2_rdata = p2[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int cnt;
        int k;
        bus0.req_i = '0; bus0.we_i = '0; bus0.addr_i = '0; bus0.wdata_i = '0; bus0.be_i = '0;
        bus1.req_i = '0; bus1.we_i = '0; bus1.addr_i = '0; bus1.wdata_i = '0; bus1.be_i = '0;
        bus2.req_i = '0; bus2.we_i = '0; bus2.addr_i = '0; bus2.wdata_i = '0; bus2.be_i = '0;
        rst_n  = 1'b0;
        rst1_n = 1'b0;

        // Reset: requests pending must not be granted.
        bus0.req_i = 4'hF;
        for (int i = 0; i < 4; i++) bus0.addr_i[i] = 10'(i);
        repeat (3) tick;
        #1;
        chk("rst_gnt",     32'(bus0.gnt_o),    32'h0);
        chk("rst_rvalid",  32'(bus0.rvalid_o), 32'h0);
        chk("rst_rdata",   bus0.rdata_o,       32'h0);
        chk("rst_sramreq", 32'(s0_req),        32'h0);
        chk("rst_rvalid1", 32'(bus1.rvalid_o), 32'h0);
        chk("rst_sramreq2", 32'(s2_req),       32'h0);
        bus0.req_i = '0;
        rst_n  = 1'b1;
        rst1_n = 1'b1;

`ifdef TC_SRAM_ARB_INIT_EN
        #1;
        chk("init_busy", 32'(bus0.init_done_o), 32'h0);
        cnt = 0;
        k   = 0;
        while (!(bus0.init_done_o && bus1.init_done_o && bus2.init_done_o) && k < 1200) begin
            if (s0_req && !bus0.init_done_o) cnt++;
            @(posedge clk);
            #3;
            k++;
        end
        chk("init_cycles", 32'(cnt), 32'd1024);
`else
        cnt = 0;
        k   = 0;
        tick;
        #1;
`endif
        chk("init_done0", 32'(bus0.init_done_o), 32'h1);
        chk("init_done1", 32'(bus1.init_done_o), 32'h1);
        chk("init_done2", 32'(bus2.init_done_o), 32'h1);

        // Fairness: all four request reads of address == index.
        tick;
        bus0.req_i = 4'hF;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("rr_gnt",  32'(bus0.gnt_o), 32'h1 << (i % 4));
            chk("rr_addr", 32'(s0_addr),    32'(i % 4));
            if (i > 0) chk("rr_rvalid", 32'(bus0.rvalid_o), 32'h1 << ((i - 1) % 4));
            tick;
            if (i == 7) bus0.req_i = '0;
            #1;
        end
        chk("idle_gnt",     32'(bus0.gnt_o),    32'h0);
        chk("idle_sramreq", 32'(s0_req),        32'h0);
        chk("idle_rvalid",  32'(bus0.rvalid_o), 32'h8);
        chk("idle_rdata",   bus0.rdata_o,       32'h0);

        // Write then read with partial byte enables.
        tick;
        bus0.req_i = 4'b0001; bus0.we_i = 4'b0001; bus0.addr_i[0] = 10'h10;
        bus0.wdata_i[0] = 32'hDEADBEEF; bus0.be_i[0] = 4'b0011;
        #1;
        chk("wr_gnt",   32'(bus0.gnt_o), 32'h1);
        chk("wr_req",   32'(s0_req),     32'h1);
        chk("wr_we",    32'(s0_we),      32'h1);
        chk("wr_addr",  32'(s0_addr),    32'h10);
        chk("wr_wdata", s0_wdata,        32'hDEADBEEF);
        chk("wr_be",    32'(s0_be),      32'h3);
        tick;
        bus0.req_i = 4'b0100; bus0.we_i = '0; bus0.addr_i[2] = 10'h10;
        #1;
        chk("rd_gnt",    32'(bus0.gnt_o),    32'h4);
        chk("rd_we",     32'(s0_we),         32'h0);
        chk("wr_noresp", 32'(bus0.rvalid_o), 32'h0);
        tick;
        bus0.req_i = 4'b0011; bus0.addr_i[1] = 10'h1;
        #1;
        chk("rd_rvalid", 32'(bus0.rvalid_o), 32'h4);
        chk("rd_rdata",  bus0.rdata_o,       32'h0000BEEF);
        chk("wrap_gnt",  32'(bus0.gnt_o),    32'h1);
        tick;
        #1;
        chk("wrap_gnt2",  32'(bus0.gnt_o),    32'h2);
        chk("rd0_rvalid", 32'(bus0.rvalid_o), 32'h1);
        chk("rd0_rdata",  bus0.rdata_o,       32'h0000BEEF);
        tick;
        bus0.req_i = '0;
        #1;
        chk("rd1_rvalid", 32'(bus0.rvalid_o), 32'h2);
        chk("rd1_rdata",  bus0.rdata_o,       32'h0);

        // Latency 3: back-to-back reads from requesters 1 and 3.
        tick;
        bus2.req_i = 4'b0010; bus2.addr_i[1] = 10'h21;
        #1;
        chk("l3_gnt1", 32'(bus2.gnt_o), 32'h2);
        tick;
        bus2.req_i = 4'b1000; bus2.addr_i[3] = 10'h33;
        #1;
        chk("l3_gnt3", 32'(bus2.gnt_o),    32'h8);
        chk("l3_t1",   32'(bus2.rvalid_o), 32'h0);
        tick;
        bus2.req_i = '0;
        #1;
        chk("l3_t2", 32'(bus2.rvalid_o), 32'h0);
        tick;
        #1;
        chk("l3_t3_vld",  32'(bus2.rvalid_o), 32'h2);
        chk("l3_t3_data", bus2.rdata_o,       32'hC0DE0021);
        tick;
        #1;
        chk("l3_t4_vld",  32'(bus2.rvalid_o), 32'h8);
        chk("l3_t4_data", bus2.rdata_o,       32'hC0DE0033);
        tick;
        #1;
        chk("l3_t5", 32'(bus2.rvalid_o), 32'h0);

        // Depth 1000: in-range read, out-of-range read and write.
        tick;
        bus1.req_i = 4'b0010; bus1.addr_i[1] = 10'd7;
        #1;
        chk("nw_gnt_ok", 32'(bus1.gnt_o), 32'h2);
        chk("nw_req_ok", 32'(s1_req),     32'h1);
        tick;
        bus1.req_i = 4'b0100; bus1.addr_i[2] = 10'd1000;
        #1;
        chk("oob_rd_gnt", 32'(bus1.gnt_o), 32'h4);
        chk("oob_rd_req", 32'(s1_req),     32'h0);
        tick;
        bus1.req_i = 4'b1000; bus1.we_i = 4'b1000; bus1.addr_i[3] = 10'd1000;
        bus1.wdata_i[3] = 32'h12345678; bus1.be_i[3] = 4'hF;
        #1;
        chk("oob_wr_gnt", 32'(bus1.gnt_o),    32'h8);
        chk("oob_wr_req", 32'(s1_req),        32'h0);
        chk("nw_vld_ok",  32'(bus1.rvalid_o), 32'h2);
        chk("nw_data_ok", bus1.rdata_o,       32'hC0DE0007);
        tick;
        bus1.req_i = '0; bus1.we_i = '0;
        #1;
        chk("oob_rd_vld",  32'(bus1.rvalid_o), 32'h4);
        chk("oob_rd_data", bus1.rdata_o,       32'h0);
        tick;
        #1;
        chk("oob_wr_noresp", 32'(bus1.rvalid_o), 32'h0);

        // Reset one cycle after a Latency-2 read: the response must vanish.
        tick;
        bus1.req_i = 4'b0001; bus1.addr_i[0] = 10'd5;
        #1;
        chk("mid_gnt", 32'(bus1.gnt_o), 32'h1);
        tick;
        bus1.req_i = '0;
        rst1_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            tick;
            #1;
            chk("mid_rvalid", 32'(bus1.rvalid_o), 32'h0);
        end
        chk("mid_rdata", bus1.rdata_o, 32'h0);
        rst1_n = 1'b1;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
